// File: rtl/rd_word_packer_pkg.sv
// Shared types and constants for the read-side byte-to-word packer.
package rd_pack_pkg;

   localparam int unsigned BYTE_W = 8;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      FPUSH = 2'd2
   } pack_state_e;

   // One keep bit per byte lane of the output word.
   function automatic int unsigned keep_w(input int unsigned bytes_per_word);
      return bytes_per_word;
   endfunction

endpackage

// File: rtl/rd_word_packer_if.sv
// FIFO read port plus word output stream of the packer.
// PACKER_PARITY_EN adds out_parity.
interface rd_word_packer_if #(
   parameter int unsigned BYTES_PER_WORD = 4
);
   import rd_pack_pkg::*;

   localparam int unsigned DW = BYTE_W * BYTES_PER_WORD;

   logic                      fifo_empty;
   logic                      rd_en;
   logic [BYTE_W-1:0]         rdata;
   logic                      rvalid;
   logic                      flush;
   logic [DW-1:0]             out_data;
   logic [BYTES_PER_WORD-1:0] out_keep;
   logic                      out_valid;
   logic                      out_ready;
   logic                      busy;
   logic                      err;
`ifdef PACKER_PARITY_EN
   logic                      out_parity;
`endif

   modport master (
      input  fifo_empty, rdata, rvalid, flush, out_ready,
`ifdef PACKER_PARITY_EN
      output out_parity,
`endif
      output rd_en, out_data, out_keep, out_valid, busy, err
   );

   modport slave (
      output fifo_empty, rdata, rvalid, flush, out_ready,
`ifdef PACKER_PARITY_EN
      input  out_parity,
`endif
      input  rd_en, out_data, out_keep, out_valid, busy, err
   );

endinterface

// File: rtl/rd_word_packer_queue.sv
// pack_word_queue: small synchronous FIFO of {data, keep[, parity]} with occupancy count.
// PACKER_PARITY_EN adds a per-entry parity bit.
module pack_word_queue #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned KEEP_W = 4,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic [DATA_W-1:0]       push_data,
   input  logic [KEEP_W-1:0]       push_keep,
`ifdef PACKER_PARITY_EN
   input  logic                    push_par,
   output logic                    head_par,
`endif
   input  logic                    pop,
   output logic [DATA_W-1:0]       head_data,
   output logic [KEEP_W-1:0]       head_keep,
   output logic [$clog2(DEPTH):0]  cnt
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DATA_W-1:0] data_d [DEPTH];
   logic [KEEP_W-1:0] keep_q [DEPTH];
   logic [KEEP_W-1:0] keep_d [DEPTH];
`ifdef PACKER_PARITY_EN
   logic              par_q  [DEPTH];
   logic              par_d  [DEPTH];
`endif
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              do_push, do_pop;

   always_comb begin
      data_d   = data_q;
      keep_d   = keep_q;
`ifdef PACKER_PARITY_EN
      par_d    = par_q;
`endif
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      do_pop   = pop && (cnt_q != '0);
      // A full queue still accepts a push when the head leaves in the same cycle.
      do_push  = push && ((cnt_q != CW'(DEPTH)) || do_pop);

      if (do_push) begin
         data_d[wr_ptr_q] = push_data;
         keep_d[wr_ptr_q] = push_keep;
`ifdef PACKER_PARITY_EN
         par_d[wr_ptr_q]  = push_par;
`endif
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (do_push && !do_pop) begin
         cnt_d = cnt_q + CW'(1);
      end else if (!do_push && do_pop) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            data_q[i] <= '0;
            keep_q[i] <= '0;
`ifdef PACKER_PARITY_EN
            par_q[i]  <= 1'b0;
`endif
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         data_q   <= data_d;
         keep_q   <= keep_d;
`ifdef PACKER_PARITY_EN
         par_q    <= par_d;
`endif
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign head_data = data_q[rd_ptr_q];
   assign head_keep = keep_q[rd_ptr_q];
`ifdef PACKER_PARITY_EN
   assign head_par  = par_q[rd_ptr_q];
`endif
   assign cnt       = cnt_q;

endmodule

// File: rtl/rd_word_packer.sv
// Read-domain packer: pulls bytes from the async FIFO, packs them little-endian into words,
// queues words with valid/ready backpressure; flush emits a partial word. PACKER_PARITY_EN adds out_parity.
module rd_word_packer
   import rd_pack_pkg::*;
#(
   parameter int unsigned BYTES_PER_WORD = 4,
   parameter int unsigned OBUF_DEPTH     = 4
) (
   input  logic             r_clk,
   input  logic             rst,
   rd_word_packer_if.master bus
);

   localparam int unsigned DW  = BYTE_W * BYTES_PER_WORD;
   localparam int unsigned KW  = keep_w(BYTES_PER_WORD);
   localparam int unsigned CW  = $clog2(BYTES_PER_WORD);
   localparam int unsigned OCW = $clog2(OBUF_DEPTH) + 1;

   pack_state_e   state_q, state_d;
   logic [CW-1:0] asm_cnt_q, asm_cnt_d;
   logic [DW-1:0] asm_data_q, asm_data_d;
   logic          inflight_q, inflight_d;
   logic          err_q, err_d;

   logic [OCW-1:0] obuf_cnt;
   logic           push;
   logic [DW-1:0]  push_data;
   logic [KW-1:0]  push_keep;
   logic           pop;
   logic           rd_en_c;

   // One queue slot stays free for a byte already in flight that may complete a word.
   assign rd_en_c = !rst && !bus.fifo_empty && (state_q == RUN) &&
                    (obuf_cnt <= OCW'(OBUF_DEPTH - 2));

   always_comb begin
      state_d    = state_q;
      asm_cnt_d  = asm_cnt_q;
      asm_data_d = asm_data_q;
      inflight_d = rd_en_c;
      err_d      = err_q;
      push       = 1'b0;
      push_data  = asm_data_q;
      push_keep  = '1;

      // Only solicited bytes land; the last lane pushes the full word and restarts.
      if (bus.rvalid && inflight_q) begin
         asm_data_d[32'(asm_cnt_q) * BYTE_W +: BYTE_W] = bus.rdata;
         if (asm_cnt_q == CW'(BYTES_PER_WORD - 1)) begin
            push       = 1'b1;
            push_data  = asm_data_d;
            push_keep  = '1;
            asm_data_d = '0;
            asm_cnt_d  = '0;
         end else begin
            asm_cnt_d = asm_cnt_q + CW'(1);
         end
      end
      if (bus.rvalid != inflight_q) begin
         err_d = 1'b1;
      end

      case (state_q)
         RUN: begin
            if (bus.flush) state_d = DRAIN;
         end
         DRAIN: begin
            if (!inflight_q) state_d = (asm_cnt_q != '0) ? FPUSH : RUN;
         end
         FPUSH: begin
            // Unused lanes are already zero because the assembler clears after every push.
            if (obuf_cnt < OCW'(OBUF_DEPTH)) begin
               push       = 1'b1;
               push_data  = asm_data_q;
               push_keep  = KW'((KW'(1) << asm_cnt_q) - KW'(1));
               asm_cnt_d  = '0;
               asm_data_d = '0;
               state_d    = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge r_clk or posedge rst) begin
      if (rst) begin
         state_q    <= RUN;
         asm_cnt_q  <= '0;
         asm_data_q <= '0;
         inflight_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         asm_cnt_q  <= asm_cnt_d;
         asm_data_q <= asm_data_d;
         inflight_q <= inflight_d;
         err_q      <= err_d;
      end
   end

   assign pop = (obuf_cnt != '0) && bus.out_ready;

   pack_word_queue #(
      .DATA_W (DW),
      .KEEP_W (KW),
      .DEPTH  (OBUF_DEPTH)
   ) u_queue (
      .clk       (r_clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .push_keep (push_keep),
`ifdef PACKER_PARITY_EN
      .push_par  (^push_data),
      .head_par  (bus.out_parity),
`endif
      .pop       (pop),
      .head_data (bus.out_data),
      .head_keep (bus.out_keep),
      .cnt       (obuf_cnt)
   );

   assign bus.rd_en     = rd_en_c;
   assign bus.out_valid = (obuf_cnt != '0);
   assign bus.busy      = (asm_cnt_q != '0) || inflight_q || (obuf_cnt != '0);
   assign bus.err       = err_q;

endmodule

// File: tb/tb_rd_word_packer.sv
// Directed bench for rd_word_packer: FIFO read-port model, word monitor, hand-computed expectations.
module tb_rd_word_packer;

   localparam int unsigned BPW   = 4;
   localparam int unsigned DEPTH = 4;

   logic r_clk = 1'b0;
   logic rst   = 1'b1;
   always #5 r_clk = ~r_clk;

   rd_word_packer_if #(.BYTES_PER_WORD(BPW)) bus ();

   rd_word_packer #(
      .BYTES_PER_WORD (BPW),
      .OBUF_DEPTH     (DEPTH)
   ) dut (
      .r_clk (r_clk),
      .rst   (rst),
      .bus   (bus)
   );

   // FIFO read-side model: data arrives one cycle after rd_en.
   logic [7:0]  fmem [0:127];
   int unsigned head = 0;
   int unsigned tail = 0;
   logic        m_rvalid = 1'b0;
   logic [7:0]  m_rdata  = 8'h00;
   logic        force_rv = 1'b0;
   logic [7:0]  force_data = 8'h00;

   assign bus.fifo_empty = (head == tail);
   assign bus.rvalid     = m_rvalid | force_rv;
   assign bus.rdata      = force_rv ? force_data : m_rdata;

   always @(posedge r_clk) begin
      m_rvalid <= bus.rd_en;
      if (bus.rd_en) begin
         m_rdata <= fmem[head];
         head    <= head + 1;
      end else begin
         m_rdata <= 8'h00;
      end
   end

   // Every accepted output word is captured in order.
   logic [31:0] cap_d [$];
   logic [3:0]  cap_k [$];
   logic        cap_p [$];

   always @(negedge r_clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         cap_d.push_back(bus.out_data);
         cap_k.push_back(bus.out_keep);
`ifdef PACKER_PARITY_EN
         cap_p.push_back(bus.out_parity);
`else
         cap_p.push_back(1'b0);
`endif
      end
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge r_clk);
      #2;
   endtask

   task automatic load(input logic [7:0] b);
      fmem[tail] = b;
      tail++;
   endtask

   task automatic wait_words(input string tag, input int n, input int budget);
      for (int i = 0; i < budget && cap_d.size() < n; i++) tick();
      chk_eq({tag, "_count"}, 64'(cap_d.size()), 64'(n));
   endtask

   task automatic chk_word(input string tag, input logic [31:0] ed, input logic [3:0] ek);
      logic [31:0] d;
      logic [3:0]  k;
      logic        p;
      chk_eq({tag, "_present"}, 64'(cap_d.size() != 0), 64'd1);
      if (cap_d.size() != 0) begin
         d = cap_d.pop_front();
         k = cap_k.pop_front();
         p = cap_p.pop_front();
         chk_eq({tag, "_data"}, 64'(d), 64'(ed));
         chk_eq({tag, "_keep"}, 64'(k), 64'(ek));
`ifdef PACKER_PARITY_EN
         chk_eq({tag, "_par"}, 64'(p), 64'(^ed));
`endif
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] ed;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;

      // Reset values
      repeat (3) tick();
      @(negedge r_clk);
      chk_eq("rst_rd_en",     64'(bus.rd_en),     64'd0);
      chk_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk_eq("rst_out_data",  64'(bus.out_data),  64'd0);
      chk_eq("rst_out_keep",  64'(bus.out_keep),  64'd0);
      chk_eq("rst_busy",      64'(bus.busy),      64'd0);
      chk_eq("rst_err",       64'(bus.err),       64'd0);
      tick();
      rst = 1'b0;

      // Two full words, little-endian
      bus.out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) load(8'(i));
      wait_words("t1", 2, 40);
      chk_word("t1_w0", 32'h04030201, 4'hF);
      chk_word("t1_w1", 32'h08070605, 4'hF);
      repeat (4) tick();
      @(negedge r_clk);
      chk_eq("t1_err",  64'(bus.err),  64'd0);
      chk_eq("t1_busy", 64'(bus.busy), 64'd0);

      // Backpressure: reads stop once three words are queued, nothing is lost
      bus.out_ready = 1'b0;
      for (int i = 0; i < 40; i++) load(8'(32'h40 + i));
      repeat (30) tick();
      @(negedge r_clk);
      chk_eq("t2_rd_en_stall",  64'(bus.rd_en),     64'd0);
      chk_eq("t2_out_valid",    64'(bus.out_valid), 64'd1);
      chk_eq("t2_fifo_left",    64'(tail - head),   64'd27);
      chk_eq("t2_no_early_pop", 64'(cap_d.size()),  64'd0);
      tick();
      bus.out_ready = 1'b1;
      wait_words("t2", 10, 200);
      for (int w = 0; w < 10; w++) begin
         for (int j = 0; j < 4; j++) ed[8*j +: 8] = 8'(32'h40 + 4*w + j);
         chk_word($sformatf("t2_w%0d", w), ed, 4'hF);
      end

      // Flush of a two-byte partial word; rd_en held low while draining
      for (int i = 0; i < 6; i++) load(8'(32'hA0 + i));
      wait_words("t3a", 1, 40);
      chk_word("t3_full", 32'hA3A2A1A0, 4'hF);
      repeat (4) tick();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      load(8'hB0);
      @(negedge r_clk);
      chk_eq("t3_rd_en_drain", 64'(bus.rd_en), 64'd0);
      tick();
      @(negedge r_clk);
      chk_eq("t3_rd_en_fpush", 64'(bus.rd_en), 64'd0);
      wait_words("t3b", 1, 20);
      chk_word("t3_partial", 32'h0000A5A4, 4'h3);
      repeat (5) tick();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      wait_words("t3c", 1, 20);
      chk_word("t3_single", 32'h000000B0, 4'h1);

      // Flush with an empty assembler: no word, back in RUN within two cycles
      repeat (3) tick();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      tick();
      load(8'hC0);
      @(negedge r_clk);
      chk_eq("t4_run_again", 64'(bus.rd_en), 64'd1);
      repeat (6) tick();
      chk_eq("t4_no_word", 64'(cap_d.size()), 64'd0);

      // Unsolicited byte: sticky error, byte discarded, assembler untouched
      force_rv   = 1'b1;
      force_data = 8'hEE;
      tick();
      force_rv = 1'b0;
      @(negedge r_clk);
      chk_eq("t5_err_set", 64'(bus.err), 64'd1);
      load(8'hC1);
      load(8'hC2);
      load(8'hC3);
      wait_words("t5", 1, 30);
      chk_word("t5_word", 32'hC3C2C1C0, 4'hF);
      repeat (3) tick();
      chk_eq("t5_err_sticky", 64'(bus.err), 64'd1);

      // Reset with two queued words and three assembled bytes
      bus.out_ready = 1'b0;
      for (int i = 0; i < 11; i++) load(8'(32'h30 + i));
      repeat (20) tick();
      @(negedge r_clk);
      chk_eq("t6_out_valid_pre", 64'(bus.out_valid), 64'd1);
      chk_eq("t6_busy_pre",      64'(bus.busy),      64'd1);
      chk_eq("t6_fifo_drained",  64'(tail - head),   64'd0);
      tick();
      rst = 1'b1;
      #1;
      chk_eq("t6_out_valid_rst", 64'(bus.out_valid), 64'd0);
      chk_eq("t6_busy_rst",      64'(bus.busy),      64'd0);
      chk_eq("t6_err_rst",       64'(bus.err),       64'd0);
      chk_eq("t6_out_data_rst",  64'(bus.out_data),  64'd0);
      repeat (2) tick();
      rst = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) tick();
      chk_eq("t6_no_stale", 64'(cap_d.size()), 64'd0);
      for (int i = 0; i < 4; i++) load(8'(32'h11 + i));
      wait_words("t6", 1, 30);
      chk_word("t6_word", 32'h14131211, 4'hF);
      repeat (3) tick();
      @(negedge r_clk);
      chk_eq("t6_err_clean", 64'(bus.err),  64'd0);
      chk_eq("t6_busy_idle", 64'(bus.busy), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
